// File: rtl/unified_mem_arbiter.sv
// Shared single-port memory arbiter for the Fetch (I) and Memory (D) pipeline ports.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE. StallF/StallM are held until the
// owner's Ack. D normally wins. I wins once it has waited STARVE_LIM cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | arbitrate; latch winner's address/we/wdata into the Mem* regs
// ST_ISSUE | MemEn high for exactly one cycle
// ST_WAIT  | count down remaining memory latency (absent when MEM_LAT=1)
// ST_RESP  | pulse owner's Ack, forward MemRData (0 for writes)
module unified_mem_arbiter #(
   parameter int AWL        = 6,
   parameter int DWL        = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           IReq,
   input  logic [AWL-1:0] IAddr,
   output logic           IAck,
   output logic [DWL-1:0] IRData,
   input  logic           DReq,
   input  logic           DWE,
   input  logic [AWL-1:0] DAddr,
   input  logic [DWL-1:0] DWData,
   output logic           DAck,
   output logic [DWL-1:0] DRData,
   output logic           MemEn,
   output logic           MemWE,
   output logic [AWL-1:0] MemAddr,
   output logic [DWL-1:0] MemWData,
   input  logic [DWL-1:0] MemRData,
   output logic           StallF,
   output logic           StallM,
   output logic           Busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   // wait_cnt is loaded with MEM_LAT-2 so WAIT lasts MEM_LAT-1 cycles.
   localparam int WAIT_LD = (MEM_LAT >= 2) ? MEM_LAT - 2 : 0;
   localparam int CW      = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
   localparam int IWW     = $clog2(STARVE_LIM + 1);

   state_t         state, state_nxt;
   logic [CW-1:0]  wait_cnt;
   logic [IWW-1:0] iwait;
   logic           owner_i;
   logic           owner_we;
   logic           req_any;
   logic           grant_i;

   assign req_any = IReq | DReq;
   assign grant_i = IReq && (!DReq || (iwait >= IWW'(STARVE_LIM)));

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and Ack/read-data steering to the owning port.
   always_comb begin
      state_nxt = state;
      IAck      = 1'b0;
      DAck      = 1'b0;
      IRData    = '0;
      DRData    = '0;
      case (state)
         ST_IDLE:  if (req_any) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (wait_cnt == '0) state_nxt = ST_RESP;
         ST_RESP: begin
            state_nxt = ST_IDLE;
            if (owner_i) begin
               IAck   = 1'b1;
               IRData = MemRData;
            end else begin
               DAck   = 1'b1;
               DRData = owner_we ? '0 : MemRData;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Grant latch, one-cycle memory strobe and latency down-counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_i  <= 1'b0;
         owner_we <= 1'b0;
         MemEn    <= 1'b0;
         MemWE    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
         wait_cnt <= '0;
      end else begin
         MemEn <= 1'b0;
         MemWE <= 1'b0;
         if (state == ST_IDLE && req_any) begin
            owner_i  <= grant_i;
            owner_we <= !grant_i && DWE;
            MemEn    <= 1'b1;
            MemWE    <= !grant_i && DWE;
            MemAddr  <= grant_i ? IAddr : DAddr;
            MemWData <= grant_i ? '0 : DWData;
         end
         if (state == ST_ISSUE)     wait_cnt <= CW'(WAIT_LD);
         else if (state == ST_WAIT) wait_cnt <= wait_cnt - CW'(1);
      end
   end

   // I-port starvation counter; counts while I is requesting but not being served.
   always_ff @(posedge CLK) begin
      if (RST || !IReq)
         iwait <= '0;
      else if (state == ST_IDLE && grant_i)
         iwait <= '0;
      else if ((state == ST_IDLE || !owner_i) && (iwait < IWW'(STARVE_LIM)))
         iwait <= iwait + IWW'(1);
   end

   assign StallF = IReq && !IAck;
   assign StallM = DReq && !DAck;
   assign Busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: u0 runs MEM_LAT=2, u1 runs MEM_LAT=1. Stimulus pushes the expected
// Ack (port, data, cycle) into a queue; a negedge monitor pops and compares on each Ack.
module tb_unified_mem_arbiter;

   typedef struct {
      bit          is_i;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t e0, e1;

   // u0 (MEM_LAT=2)
   logic        IReq0, IAck0, DReq0, DWE0, DAck0, MemEn0, MemWE0, StallF0, StallM0, Busy0;
   logic [5:0]  IAddr0, DAddr0, MemAddr0;
   logic [31:0] IRData0, DWData0, DRData0, MemWData0, MemRData0;
   // u1 (MEM_LAT=1)
   logic        IReq1, IAck1, DReq1, DWE1, DAck1, MemEn1, MemWE1, StallF1, StallM1, Busy1;
   logic [5:0]  IAddr1, DAddr1, MemAddr1;
   logic [31:0] IRData1, DWData1, DRData1, MemWData1, MemRData1;

   logic [31:0] mem0 [64];
   logic [31:0] mem1 [64];
   logic [31:0] pipe0 [2];
   logic [31:0] pipe1;
   logic [31:0] rd0, rd1;

   assign MemRData0 = pipe0[1];
   assign MemRData1 = pipe1;

   unified_mem_arbiter #(.AWL(6), .DWL(32), .MEM_LAT(2), .STARVE_LIM(4)) u0 (
      .CLK(CLK), .RST(RST),
      .IReq(IReq0), .IAddr(IAddr0), .IAck(IAck0), .IRData(IRData0),
      .DReq(DReq0), .DWE(DWE0), .DAddr(DAddr0), .DWData(DWData0), .DAck(DAck0), .DRData(DRData0),
      .MemEn(MemEn0), .MemWE(MemWE0), .MemAddr(MemAddr0), .MemWData(MemWData0),
      .MemRData(MemRData0), .StallF(StallF0), .StallM(StallM0), .Busy(Busy0));

   unified_mem_arbiter #(.AWL(6), .DWL(32), .MEM_LAT(1), .STARVE_LIM(4)) u1 (
      .CLK(CLK), .RST(RST),
      .IReq(IReq1), .IAddr(IAddr1), .IAck(IAck1), .IRData(IRData1),
      .DReq(DReq1), .DWE(DWE1), .DAddr(DAddr1), .DWData(DWData1), .DAck(DAck1), .DRData(DRData1),
      .MemEn(MemEn1), .MemWE(MemWE1), .MemAddr(MemAddr1), .MemWData(MemWData1),
      .MemRData(MemRData1), .StallF(StallF1), .StallM(StallM1), .Busy(Busy1));

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Memory model for u0: data appears two cycles after the MemEn cycle, 0 otherwise.
   initial begin
      for (int i = 0; i < 64; i++) mem0[i] = 32'hA5A5_0000 | 32'(i);
      mem0[5]  = 32'hDEAD_BEEF;
      pipe0[0] = '0;
      pipe0[1] = '0;
      forever begin
         @(posedge CLK);
         rd0 = '0;
         if (MemEn0) begin
            rd0 = mem0[MemAddr0];
            if (MemWE0) mem0[MemAddr0] = MemWData0;
         end
         pipe0[1] = pipe0[0];
         pipe0[0] = rd0;
      end
   end

   // Memory model for u1: data appears one cycle after the MemEn cycle.
   initial begin
      for (int i = 0; i < 64; i++) mem1[i] = 32'h5A5A_0000 | 32'(i);
      pipe1 = '0;
      forever begin
         @(posedge CLK);
         rd1 = '0;
         if (MemEn1) begin
            rd1 = mem1[MemAddr1];
            if (MemWE1) mem1[MemAddr1] = MemWData1;
         end
         pipe1 = rd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(input int which, input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         case (which)
            0:       seen = IAck0;
            1:       seen = DAck0;
            default: seen = DAck1;
         endcase
      end
      check(name, 32'(seen), 32'd1);
   endtask

   // Monitor: pop and compare on every Ack; read data must be 0 whenever no Ack is up.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (IAck0 || DAck0) begin
            if (sb0.size() == 0) begin
               check("u0_unexpected_ack", {30'b0, IAck0, DAck0}, 32'h0);
            end else begin
               e0 = sb0.pop_front();
               check("u0_ack_port", 32'(IAck0), 32'(e0.is_i));
               check("u0_rdata", IAck0 ? IRData0 : DRData0, e0.data);
               check("u0_ack_cycle", 32'(cyc), 32'(e0.cyc));
            end
         end else begin
            check("u0_idle_rdata", IRData0 | DRData0, 32'h0);
         end
         if (IAck1 || DAck1) begin
            if (sb1.size() == 0) begin
               check("u1_unexpected_ack", {30'b0, IAck1, DAck1}, 32'h0);
            end else begin
               e1 = sb1.pop_front();
               check("u1_ack_port", 32'(IAck1), 32'(e1.is_i));
               check("u1_rdata", IAck1 ? IRData1 : DRData1, e1.data);
               check("u1_ack_cycle", 32'(cyc), 32'(e1.cyc));
            end
         end
      end
   end

   initial begin
      int c;
      IReq0 = 1'b1; IAddr0 = '0; DReq0 = 1'b0; DWE0 = 1'b0; DAddr0 = '0; DWData0 = '0;
      IReq1 = 1'b0; IAddr1 = '0; DReq1 = 1'b0; DWE1 = 1'b0; DAddr1 = '0; DWData1 = '0;
      RST = 1'b1;

      // Reset held two cycles with IReq=1
      for (int k = 0; k < 2; k++) begin
         step();
         check("rst_iack", 32'(IAck0), 32'd0);
         check("rst_dack", 32'(DAck0), 32'd0);
         check("rst_memen", 32'(MemEn0), 32'd0);
         check("rst_busy", 32'(Busy0), 32'd0);
         check("rst_stallf", 32'(StallF0), 32'd1);
         check("rst_stallm", 32'(StallM0), 32'd0);
         check("rst_memwe_addr", {25'b0, MemWE0, MemAddr0}, 32'd0);
         check("rst_irdata", IRData0, 32'd0);
         mon_en = 1'b1;
      end
      IReq0 = 1'b0;
      RST   = 1'b0;
      step();

      // Single fetch read of mem[5]
      c = cyc;
      IAddr0 = 6'd5; IReq0 = 1'b1;
      sb0.push_back('{1'b1, 32'hDEAD_BEEF, c + 3});
      step();
      check("t2_memen", 32'(MemEn0), 32'd1);
      check("t2_memaddr", 32'(MemAddr0), 32'd5);
      check("t2_memwe", 32'(MemWE0), 32'd0);
      wait_ack(0, "t2_iack_seen");
      check("t2_stallf", 32'(StallF0), 32'd0);
      step();
      IReq0 = 1'b0;
      step();

      // Simultaneous requests: D write wins, I read follows
      c = cyc;
      IAddr0 = 6'd3; IReq0 = 1'b1;
      DReq0 = 1'b1; DWE0 = 1'b1; DAddr0 = 6'd9; DWData0 = 32'h1234;
      sb0.push_back('{1'b0, 32'h0, c + 3});
      sb0.push_back('{1'b1, 32'hA5A5_0003, c + 7});
      step();
      check("t3_memwe", 32'(MemWE0), 32'd1);
      check("t3_memaddr", 32'(MemAddr0), 32'd9);
      check("t3_memwdata", MemWData0, 32'h1234);
      wait_ack(1, "t3_dack_seen");
      step();
      DReq0 = 1'b0; DWE0 = 1'b0; DWData0 = 32'hFFFF_FFFF;
      step();
      check("t3_i_issue", 32'(MemEn0), 32'd1);
      check("t3_i_addr", 32'(MemAddr0), 32'd3);
      wait_ack(0, "t3_iack_seen");
      step();
      IReq0 = 1'b0;
      step();

      // Read back the written word
      c = cyc;
      DReq0 = 1'b1; DAddr0 = 6'd9;
      sb0.push_back('{1'b0, 32'h1234, c + 3});
      wait_ack(1, "t3_rb_seen");
      step();
      DReq0 = 1'b0;
      step();

      // Starvation: D held continuously, I overrides after one D access
      c = cyc;
      DReq0 = 1'b1; DAddr0 = 6'd7; IReq0 = 1'b1; IAddr0 = 6'd1;
      sb0.push_back('{1'b0, 32'hA5A5_0007, c + 3});
      sb0.push_back('{1'b1, 32'hA5A5_0001, c + 7});
      sb0.push_back('{1'b0, 32'hA5A5_0008, c + 11});
      wait_ack(1, "t4_d1_seen");
      step();
      DAddr0 = 6'd8;
      step();
      check("t4_i_wins_addr", 32'(MemAddr0), 32'd1);
      wait_ack(0, "t4_iack_seen");
      step();
      IReq0 = 1'b0;
      wait_ack(1, "t4_d2_seen");
      step();
      DReq0 = 1'b0;
      step();

      // Reset during WAIT: no Ack, then a fresh request is served
      DReq0 = 1'b1; DAddr0 = 6'd4;
      step();
      step();
      check("t5_busy_wait", 32'(Busy0), 32'd1);
      RST = 1'b1; DReq0 = 1'b0;
      step();
      RST = 1'b0;
      check("t5_busy", 32'(Busy0), 32'd0);
      check("t5_dack", 32'(DAck0), 32'd0);
      check("t5_memen", 32'(MemEn0), 32'd0);
      step();
      c = cyc;
      DReq0 = 1'b1; DAddr0 = 6'd6;
      sb0.push_back('{1'b0, 32'hA5A5_0006, c + 3});
      wait_ack(1, "t5_fresh_seen");
      step();
      DReq0 = 1'b0;
      step();

      // MEM_LAT=1 instance: D read of mem[2], no WAIT state
      c = cyc;
      DReq1 = 1'b1; DAddr1 = 6'd2;
      sb1.push_back('{1'b0, 32'h5A5A_0002, c + 2});
      step();
      check("t6_memen", 32'(MemEn1), 32'd1);
      check("t6_memaddr", 32'(MemAddr1), 32'd2);
      step();
      check("t6_dack", 32'(DAck1), 32'd1);
      check("t6_stallm", 32'(StallM1), 32'd0);
      step();
      DReq1 = 1'b0;
      check("t6_idle", 32'(Busy1), 32'd0);

      repeat (3) step();
      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
